// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: PC-write, fetch/decode enable and flush controls,
// load-use stall, taken-branch squash, CALL/RET beat sequencing and a stall counter.
module pipeline_ctrl #(
   parameter int unsigned RA_W  = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             decValid,
   input  logic [RA_W-1:0]  decSrc1,
   input  logic [RA_W-1:0]  decSrc2,
   input  logic             decUsesSrc1,
   input  logic             decUsesSrc2,
   input  logic             decIsCall,
   input  logic             decIsRet,
   input  logic             exMR,
   input  logic [RA_W-1:0]  exRd,
   input  logic             exBranchTaken,
   input  logic             retPcValid,
   input  logic             perfClr,
   output logic             pcWrite,
   output logic             fdEnable,
   output logic             fdFlush,
   output logic             deFlush,
   output logic [1:0]       firstTimeCall,
   output logic [1:0]       firstTimeRET,
   output logic [2:0]       ctrlState,
   output logic [CNT_W-1:0] stallCnt
);

   localparam logic [2:0] S_RUN   = 3'd0;
   localparam logic [2:0] S_CALL1 = 3'd1;
   localparam logic [2:0] S_CALL2 = 3'd2;
   localparam logic [2:0] S_RET1  = 3'd3;
   localparam logic [2:0] S_RET2  = 3'd4;
   localparam logic [2:0] S_RETW  = 3'd5;

   localparam logic [1:0] BEAT_NONE = 2'b00;
   localparam logic [1:0] BEAT_1    = 2'b01;
   localparam logic [1:0] BEAT_2    = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   logic             src1_hit, src2_hit;

   // Decode instruction reads the register an in-flight load has not yet produced
   always_comb begin
      src1_hit = decUsesSrc1 & (decSrc1 == exRd);
      src2_hit = decUsesSrc2 & (decSrc2 == exRd);
      load_use = exMR & decValid & (src1_hit | src2_hit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_RUN;
      case (state_q)
         S_RUN: begin
            if (exBranchTaken || load_use) begin
               state_d = S_RUN;
            end else if (decValid && decIsCall) begin
               state_d = S_CALL1;
            end else if (decValid && decIsRet) begin
               state_d = S_RET1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_CALL1: state_d = S_RUN;
         S_RET1:  state_d = S_RET2;
         S_RET2:  state_d = S_RETW;
         S_RETW:  state_d = retPcValid ? S_RUN : S_RETW;
         S_CALL2: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      pcWrite       = 1'b1;
      fdEnable      = 1'b1;
      fdFlush       = 1'b0;
      deFlush       = 1'b0;
      firstTimeCall = BEAT_NONE;
      firstTimeRET  = BEAT_NONE;
      case (state_q)
         S_RUN: begin
            if (exBranchTaken) begin
               fdFlush = 1'b1;
               deFlush = 1'b1;
            end else if (load_use) begin
               pcWrite  = 1'b0;
               fdEnable = 1'b0;
               deFlush  = 1'b1;
            end else if (decValid && decIsCall) begin
               pcWrite       = 1'b0;
               fdEnable      = 1'b0;
               firstTimeCall = BEAT_1;
            end else if (decValid && decIsRet) begin
               pcWrite      = 1'b0;
               fdEnable     = 1'b0;
               firstTimeRET = BEAT_1;
            end
         end
         // Second CALL beat loads the target PC and squashes the fetched slot
         S_CALL1: begin
            firstTimeCall = BEAT_2;
            fdFlush       = 1'b1;
         end
         S_RET1: begin
            firstTimeRET = BEAT_2;
            pcWrite      = 1'b0;
            fdFlush      = 1'b1;
         end
         S_RET2: begin
            pcWrite  = 1'b0;
            fdEnable = 1'b0;
            deFlush  = 1'b1;
         end
         // Hold fetch with bubbles until the popped return PC arrives
         S_RETW: begin
            if (retPcValid) begin
               fdFlush = 1'b1;
            end else begin
               pcWrite  = 1'b0;
               fdEnable = 1'b0;
               deFlush  = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (perfClr) begin
         cnt_d = '0;
      end else if (!pcWrite && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ctrlState = state_q;
   assign stallCnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand sequences for multi-cycle
// corners and random stimulus against a schedule-queue reference model.
module tb_pipeline_ctrl;

   localparam int unsigned RA_W  = 3;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             decValid, decUsesSrc1, decUsesSrc2, decIsCall, decIsRet;
   logic [RA_W-1:0]  decSrc1, decSrc2, exRd;
   logic             exMR, exBranchTaken, retPcValid, perfClr;
   logic             pcWrite, fdEnable, fdFlush, deFlush;
   logic [1:0]       firstTimeCall, firstTimeRET;
   logic [2:0]       ctrlState;
   logic [CNT_W-1:0] stallCnt;

   pipeline_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .decValid(decValid), .decSrc1(decSrc1), .decSrc2(decSrc2),
      .decUsesSrc1(decUsesSrc1), .decUsesSrc2(decUsesSrc2),
      .decIsCall(decIsCall), .decIsRet(decIsRet),
      .exMR(exMR), .exRd(exRd), .exBranchTaken(exBranchTaken),
      .retPcValid(retPcValid), .perfClr(perfClr),
      .pcWrite(pcWrite), .fdEnable(fdEnable), .fdFlush(fdFlush), .deFlush(deFlush),
      .firstTimeCall(firstTimeCall), .firstTimeRET(firstTimeRET),
      .ctrlState(ctrlState), .stallCnt(stallCnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       dv;
      logic [2:0] s1;
      logic       u1;
      logic [2:0] s2;
      logic       u2;
      logic       is_call;
      logic       is_ret;
      logic       mr;
      logic [2:0] rd;
      logic       br;
      logic       rpv;
      logic       clr;
   } in_t;

   typedef struct packed {
      logic       pcw;
      logic       fde;
      logic       fdf;
      logic       def;
      logic [1:0] cb;
      logic [1:0] rb;
      logic [2:0] st;
   } out_t;

   typedef struct packed {
      out_t o;
      logic then_wait;
   } sched_t;

   typedef struct packed {
      in_t  i;
      out_t e;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // Reference model: queued forced-output cycles plus an unbounded return-PC wait
   sched_t           q[$];
   bit               wait_ret;
   logic [CNT_W-1:0] m_cnt;

   function automatic in_t mk_in(logic dv, logic [2:0] s1, logic u1, logic [2:0] s2, logic u2,
                                 logic c, logic r, logic mr, logic [2:0] rd, logic br,
                                 logic rpv, logic clr);
      in_t x;
      x.dv = dv; x.s1 = s1; x.u1 = u1; x.s2 = s2; x.u2 = u2; x.is_call = c; x.is_ret = r;
      x.mr = mr; x.rd = rd; x.br = br; x.rpv = rpv; x.clr = clr;
      return x;
   endfunction

   function automatic out_t mk_out(logic pcw, logic fde, logic fdf, logic def,
                                   logic [1:0] cb, logic [1:0] rb, logic [2:0] st);
      out_t o;
      o.pcw = pcw; o.fde = fde; o.fdf = fdf; o.def = def; o.cb = cb; o.rb = rb; o.st = st;
      return o;
   endfunction

   function automatic bit is_lu(in_t x);
      return x.mr && x.dv && ((x.u1 && x.s1 == x.rd) || (x.u2 && x.s2 == x.rd));
   endfunction

   function automatic out_t model_out(in_t x);
      if (q.size() > 0) return q[0].o;
      if (wait_ret) return x.rpv ? mk_out(1, 1, 1, 0, 0, 0, 5) : mk_out(0, 0, 0, 1, 0, 0, 5);
      if (x.br) return mk_out(1, 1, 1, 1, 0, 0, 0);
      if (is_lu(x)) return mk_out(0, 0, 0, 1, 0, 0, 0);
      if (x.dv && x.is_call) return mk_out(0, 0, 0, 0, 1, 0, 0);
      if (x.dv && x.is_ret) return mk_out(0, 0, 0, 0, 0, 1, 0);
      return mk_out(1, 1, 0, 0, 0, 0, 0);
   endfunction

   task automatic model_step(input in_t x, input out_t e);
      sched_t s;
      if (q.size() > 0) begin
         s = q.pop_front();
         if (s.then_wait) wait_ret = 1'b1;
      end else if (wait_ret) begin
         if (x.rpv) wait_ret = 1'b0;
      end else if (!x.br && !is_lu(x)) begin
         if (x.dv && x.is_call) begin
            s.o = mk_out(1, 1, 1, 0, 2, 0, 1); s.then_wait = 1'b0; q.push_back(s);
         end else if (x.dv && x.is_ret) begin
            s.o = mk_out(0, 1, 1, 0, 0, 2, 3); s.then_wait = 1'b0; q.push_back(s);
            s.o = mk_out(0, 0, 0, 1, 0, 0, 4); s.then_wait = 1'b1; q.push_back(s);
         end
      end
      if (x.clr) m_cnt = '0;
      else if (!e.pcw && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
   endtask

   task automatic model_reset();
      q.delete();
      wait_ret = 1'b0;
      m_cnt = '0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply(input in_t x);
      decValid = x.dv; decSrc1 = x.s1; decUsesSrc1 = x.u1; decSrc2 = x.s2; decUsesSrc2 = x.u2;
      decIsCall = x.is_call; decIsRet = x.is_ret; exMR = x.mr; exRd = x.rd;
      exBranchTaken = x.br; retPcValid = x.rpv; perfClr = x.clr;
   endtask

   function automatic out_t dut_out();
      return mk_out(pcWrite, fdEnable, fdFlush, deFlush, firstTimeCall, firstTimeRET, ctrlState);
   endfunction

   // One clock: drive after the falling edge, sample mid-low-phase, advance model at rising edge
   task automatic cycle(input in_t x, input bit chk, output out_t got, output logic [CNT_W-1:0] sc);
      out_t e;
      apply(x);
      #2;
      e = model_out(x);
      got = dut_out();
      sc = stallCnt;
      if (chk) begin
         check("model_outputs", 32'(got), 32'(e));
         check("model_stallCnt", 32'(sc), 32'(m_cnt));
      end
      @(posedge clk);
      model_step(x, e);
      @(negedge clk);
   endtask

   in_t              idle, lu_in, x;
   out_t             got, dflt;
   logic [CNT_W-1:0] sc;
   vec_t             tbl[9];

   initial begin
      idle  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      lu_in = mk_in(1, 0, 0, 3, 1, 0, 0, 1, 3, 0, 0, 0);
      dflt  = mk_out(1, 1, 0, 0, 0, 0, 0);

      tbl[0] = '{i: idle, e: dflt};
      tbl[1] = '{i: mk_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0), e: mk_out(0, 0, 0, 1, 0, 0, 0)};
      tbl[2] = '{i: mk_in(1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0), e: dflt};
      tbl[3] = '{i: mk_in(0, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0), e: dflt};
      tbl[4] = '{i: mk_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0), e: mk_out(1, 1, 1, 1, 0, 0, 0)};
      tbl[5] = '{i: mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), e: mk_out(1, 1, 1, 1, 0, 0, 0)};
      tbl[6] = '{i: mk_in(1, 2, 0, 2, 1, 0, 1, 1, 2, 0, 0, 0), e: mk_out(0, 0, 0, 1, 0, 0, 0)};
      tbl[7] = '{i: mk_in(1, 5, 1, 5, 1, 0, 0, 0, 5, 0, 0, 0), e: dflt};
      tbl[8] = '{i: mk_in(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0), e: dflt};

      model_reset();
      apply(idle);
      #3;
      check("reset_outputs", 32'(dut_out()), 32'(dflt));
      check("reset_stallCnt", 32'(stallCnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle RUN decisions with hand-computed expectations
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].i, 1'b1, got, sc);
         check($sformatf("table_%0d", i), 32'(got), 32'(tbl[i].e));
      end

      // Load-use: one stall, then the re-evaluated instruction proceeds
      cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, got, sc);
      cycle(lu_in, 1'b1, got, sc);
      check("lu_stall", 32'(got), 32'(mk_out(0, 0, 0, 1, 0, 0, 0)));
      x = lu_in; x.mr = 1'b0;
      cycle(x, 1'b1, got, sc);
      check("lu_release", 32'(got), 32'(dflt));
      check("lu_stallCnt", 32'(sc), 32'd1);

      // Branch overrides load-use and does not count as a stall
      x = lu_in; x.br = 1'b1;
      cycle(x, 1'b1, got, sc);
      check("br_over_lu", 32'(got), 32'(mk_out(1, 1, 1, 1, 0, 0, 0)));
      cycle(idle, 1'b1, got, sc);
      check("br_stallCnt", 32'(sc), 32'd1);

      // CALL: beat 01, beat 10, back to RUN
      cycle(mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, got, sc);
      check("call_beat1", 32'(got), 32'(mk_out(0, 0, 0, 0, 1, 0, 0)));
      x = lu_in; x.br = 1'b1;
      cycle(x, 1'b1, got, sc);
      check("call_beat2", 32'(got), 32'(mk_out(1, 1, 1, 0, 2, 0, 1)));
      cycle(idle, 1'b1, got, sc);
      check("call_done", 32'(got), 32'(dflt));

      // RET with three wait cycles; early retPcValid ignored
      cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, got, sc);
      cycle(mk_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, got, sc);
      check("ret_beat1", 32'(got), 32'(mk_out(0, 0, 0, 0, 0, 1, 0)));
      x = idle; x.rpv = 1'b1;
      cycle(x, 1'b1, got, sc);
      check("ret_beat2", 32'(got), 32'(mk_out(0, 1, 1, 0, 0, 2, 3)));
      cycle(x, 1'b1, got, sc);
      check("ret2", 32'(got), 32'(mk_out(0, 0, 0, 1, 0, 0, 4)));
      for (int i = 0; i < 3; i++) begin
         cycle(idle, 1'b1, got, sc);
         check($sformatf("retw_%0d", i), 32'(got), 32'(mk_out(0, 0, 0, 1, 0, 0, 5)));
      end
      cycle(x, 1'b1, got, sc);
      check("ret_reload", 32'(got), 32'(mk_out(1, 1, 1, 0, 0, 0, 5)));
      check("ret_stallCnt", 32'(sc), 32'd6);
      cycle(idle, 1'b1, got, sc);
      check("ret_done", 32'(got), 32'(dflt));

      // Asynchronous reset while waiting in RETW
      cycle(mk_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, got, sc);
      cycle(idle, 1'b1, got, sc);
      cycle(idle, 1'b1, got, sc);
      apply(idle);
      #1;
      check("pre_reset_state", 32'(ctrlState), 32'd5);
      rst_n = 1'b0;
      #1;
      check("async_state", 32'(ctrlState), 32'd0);
      check("async_stallCnt", 32'(stallCnt), 32'd0);
      check("async_pcWrite", 32'(pcWrite), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation, then clear during a stall
      for (int i = 0; i < 65540; i++) cycle(lu_in, 1'b0, got, sc);
      cycle(lu_in, 1'b1, got, sc);
      check("sat_stallCnt", 32'(sc), 32'hFFFF);
      x = lu_in; x.clr = 1'b1;
      cycle(x, 1'b1, got, sc);
      cycle(idle, 1'b1, got, sc);
      check("clr_stallCnt", 32'(sc), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         x.dv = ($urandom_range(0, 3) != 0);
         x.s1 = 3'($urandom_range(0, 3));
         x.s2 = 3'($urandom_range(0, 3));
         x.u1 = 1'($urandom);
         x.u2 = 1'($urandom);
         x.is_call = ($urandom_range(0, 7) == 0);
         x.is_ret = ($urandom_range(0, 7) == 0);
         x.mr = ($urandom_range(0, 2) == 0);
         x.rd = 3'($urandom_range(0, 3));
         x.br = ($urandom_range(0, 7) == 0);
         x.rpv = ($urandom_range(0, 2) == 0);
         x.clr = ($urandom_range(0, 49) == 0);
         cycle(x, 1'b1, got, sc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
